// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Tracks destination tags in EX/MEM/WB and produces registered operand-mux selects plus a stall.
module fwd_hazard_ctrl #(
  parameter int unsigned REG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall
);

  localparam logic [1:0] SelRegFile = 2'b00;
  localparam logic [1:0] SelExMem   = 2'b01;
  localparam logic [1:0] SelMemWb   = 2'b10;

  // Pipeline destination tags
  logic [REG_W-1:0] ex_rd_q, ex_rd_d;
  logic             ex_we_q, ex_we_d;
  logic             ex_ld_q, ex_ld_d;
  logic [REG_W-1:0] mem_rd_q;
  logic             mem_we_q;
  logic [REG_W-1:0] wb_rd_q;
  logic             wb_we_q;

  // Registered operand selects for the instruction in EX
  logic [1:0] fwd_a_q, fwd_a_d;
  logic [1:0] fwd_b_q, fwd_b_d;

  logic hz;
  logic rs1_hit_ex, rs2_hit_ex;
  logic issue;

  // Newer producer (EX) wins over older (MEM); x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic             use_src,
    input logic [REG_W-1:0] src,
    input logic             ex_we,
    input logic [REG_W-1:0] ex_rd,
    input logic             mem_we,
    input logic [REG_W-1:0] mem_rd
  );
    logic [1:0] sel;
    sel = SelRegFile;
    if (use_src && (src != '0)) begin
      if (ex_we && (ex_rd == src)) begin
        sel = SelExMem;
      end else if (mem_we && (mem_rd == src)) begin
        sel = SelMemWb;
      end
    end
    return sel;
  endfunction

  // Load-use detection against the instruction currently in EX
  always_comb begin
    rs1_hit_ex = id_use_rs1 && (id_rs1 == ex_rd_q);
    rs2_hit_ex = id_use_rs2 && (id_rs2 == ex_rd_q);
    hz         = id_valid && ex_ld_q && ex_we_q && (ex_rd_q != '0) && (rs1_hit_ex || rs2_hit_ex);
    stall      = hz && !flush;
    issue      = id_valid && !flush && !hz;
  end

  // Next EX tags and selects; a non-issuing ID becomes a bubble
  always_comb begin
    ex_rd_d = '0;
    ex_we_d = 1'b0;
    ex_ld_d = 1'b0;
    fwd_a_d = SelRegFile;
    fwd_b_d = SelRegFile;
    if (issue) begin
      // rd is kept zero for non-writers so an idle tag never looks like a producer
      ex_rd_d = id_regwrite ? id_rd : '0;
      ex_we_d = id_regwrite;
      ex_ld_d = id_memread;
      fwd_a_d = fwd_sel(id_use_rs1, id_rs1, ex_we_q, ex_rd_q, mem_we_q, mem_rd_q);
      fwd_b_d = fwd_sel(id_use_rs2, id_rs2, ex_we_q, ex_rd_q, mem_we_q, mem_rd_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd_q  <= '0;
      ex_we_q  <= 1'b0;
      ex_ld_q  <= 1'b0;
      mem_rd_q <= '0;
      mem_we_q <= 1'b0;
      wb_rd_q  <= '0;
      wb_we_q  <= 1'b0;
      fwd_a_q  <= SelRegFile;
      fwd_b_q  <= SelRegFile;
    end else if (!hold) begin
      wb_rd_q  <= mem_rd_q;
      wb_we_q  <= mem_we_q;
      mem_rd_q <= ex_rd_q;
      mem_we_q <= ex_we_q;
      ex_rd_q  <= ex_rd_d;
      ex_we_q  <= ex_we_d;
      ex_ld_q  <= ex_ld_d;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;

  // WB carries the write-back tag only; the register file is write-first, so no WB forwarding.
  assert property (@(posedge clk) disable iff (!rst_n)
    (wb_we_q || (wb_rd_q == '0)) && (fwd_a_q != 2'b11) && (fwd_b_q != 2'b11));

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a stage-list reference model.
module tb_fwd_hazard_ctrl;

  localparam int unsigned REG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             hold = 1'b0;
  logic             flush = 1'b0;
  logic             id_valid = 1'b0;
  logic [REG_W-1:0] id_rs1 = '0;
  logic [REG_W-1:0] id_rs2 = '0;
  logic             id_use_rs1 = 1'b0;
  logic             id_use_rs2 = 1'b0;
  logic [REG_W-1:0] id_rd = '0;
  logic             id_regwrite = 1'b0;
  logic             id_memread = 1'b0;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             stall;

  int nchecks = 0;
  int nerrors = 0;

  fwd_hazard_ctrl #(.REG_W(REG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold       (hold),
    .flush      (flush),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .id_rd      (id_rd),
    .id_regwrite(id_regwrite),
    .id_memread (id_memread),
    .fwd_a_sel  (fwd_a_sel),
    .fwd_b_sel  (fwd_b_sel),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Instruction records per stage; a bubble is an all-zero record.
  typedef struct packed {
    logic             we;
    logic             ld;
    logic [REG_W-1:0] rd;
  } instr_t;

  instr_t     m_ex  = '0;
  instr_t     m_mem = '0;
  logic [1:0] m_sela = 2'b00;
  logic [1:0] m_selb = 2'b00;

  // Search producers newest-first; code is 1 + age of the producer.
  function automatic logic [1:0] model_sel(input logic use_s, input logic [REG_W-1:0] s,
                                           input instr_t ex, input instr_t mem);
    instr_t prod[2];
    prod[0] = ex;
    prod[1] = mem;
    if (!use_s || s == 0) return 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (prod[i].we && prod[i].rd == s) return 2'(i + 1);
    end
    return 2'b00;
  endfunction

  function automatic logic model_hz();
    return id_valid && m_ex.ld && m_ex.we && (m_ex.rd != 0) &&
           ((id_use_rs1 && id_rs1 == m_ex.rd) || (id_use_rs2 && id_rs2 == m_ex.rd));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ex   <= '0;
      m_mem  <= '0;
      m_sela <= 2'b00;
      m_selb <= 2'b00;
    end else if (!hold) begin
      m_mem <= m_ex;
      if (id_valid && !flush && !model_hz()) begin
        m_ex   <= '{we: id_regwrite, ld: id_memread, rd: id_rd};
        m_sela <= model_sel(id_use_rs1, id_rs1, m_ex, m_mem);
        m_selb <= model_sel(id_use_rs2, id_rs2, m_ex, m_mem);
      end else begin
        m_ex   <= '0;
        m_sela <= 2'b00;
        m_selb <= 2'b00;
      end
    end
  end

  // Per-cycle compare, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_sel_a", 32'(fwd_a_sel), 32'(m_sela));
      chk("model_sel_b", 32'(fwd_b_sel), 32'(m_selb));
      chk("model_stall", 32'(stall), 32'(model_hz() && !flush));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int v, input int rs1, input int u1, input int rs2, input int u2,
                       input int rd, input int rw, input int mr);
    id_valid    = v[0];
    id_rs1      = REG_W'(rs1);
    id_use_rs1  = u1[0];
    id_rs2      = REG_W'(rs2);
    id_use_rs2  = u2[0];
    id_rd       = REG_W'(rd);
    id_regwrite = rw[0];
    id_memread  = mr[0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    hold  = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset with arbitrary inputs
    drive(1, 3, 1, 7, 1, 9, 1, 1);
    flush = 1'b1;
    #3;
    chk("rst_sel_a", 32'(fwd_a_sel), 0);
    chk("rst_sel_b", 32'(fwd_b_sel), 0);
    chk("rst_stall", 32'(stall), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(2);
    chk("post_rst_sel_a", 32'(fwd_a_sel), 0);
    chk("post_rst_sel_b", 32'(fwd_b_sel), 0);
    chk("post_rst_stall", 32'(stall), 0);

    // ALU chain, adjacent: both operands from EX/MEM
    idle(3);
    drive(1, 1, 1, 2, 1, 5, 1, 0); step();
    drive(1, 5, 1, 5, 1, 6, 1, 0); step();
    chk("alu_adj_a", 32'(fwd_a_sel), 32'(2'b01));
    chk("alu_adj_b", 32'(fwd_b_sel), 32'(2'b01));

    // ALU chain with one unrelated instruction between: from MEM/WB
    idle(3);
    drive(1, 1, 1, 2, 1, 5, 1, 0); step();
    drive(1, 10, 1, 11, 1, 9, 1, 0); step();
    drive(1, 5, 1, 5, 1, 6, 1, 0); step();
    chk("alu_gap_a", 32'(fwd_a_sel), 32'(2'b10));
    chk("alu_gap_b", 32'(fwd_b_sel), 32'(2'b10));

    // Load-use: one stall cycle, a bubble, then MEM/WB forward on rs2
    idle(3);
    drive(1, 0, 0, 0, 0, 7, 1, 1); step();
    drive(1, 1, 1, 7, 1, 8, 1, 0);
    #1;
    chk("lu_stall", 32'(stall), 1);
    step();
    chk("lu_bubble_a", 32'(fwd_a_sel), 0);
    chk("lu_bubble_b", 32'(fwd_b_sel), 0);
    chk("lu_stall_drop", 32'(stall), 0);
    step();
    chk("lu_fwd_a", 32'(fwd_a_sel), 0);
    chk("lu_fwd_b", 32'(fwd_b_sel), 32'(2'b10));

    // x0 producer is never forwarded
    idle(3);
    drive(1, 0, 0, 0, 0, 0, 1, 0); step();
    drive(1, 0, 1, 0, 1, 4, 1, 0); step();
    chk("x0_a", 32'(fwd_a_sel), 0);
    chk("x0_b", 32'(fwd_b_sel), 0);

    // Same rd in MEM and EX: newest wins
    idle(3);
    drive(1, 0, 0, 0, 0, 3, 1, 0); step();
    drive(1, 0, 0, 0, 0, 3, 1, 0); step();
    drive(1, 3, 1, 3, 1, 4, 1, 0); step();
    chk("prio_a", 32'(fwd_a_sel), 32'(2'b01));
    chk("prio_b", 32'(fwd_b_sel), 32'(2'b01));

    // Flush masks stall and drops the ID instruction
    idle(3);
    drive(1, 0, 0, 0, 0, 7, 1, 1); step();
    drive(1, 0, 0, 7, 1, 8, 1, 0);
    flush = 1'b1;
    #1;
    chk("flush_stall", 32'(stall), 0);
    step();
    flush = 1'b0;
    drive(1, 8, 1, 7, 1, 9, 1, 0); step();
    chk("flush_drop_a", 32'(fwd_a_sel), 0);
    chk("flush_load_b", 32'(fwd_b_sel), 32'(2'b10));

    // Hold freezes state; stall keeps following the hazard
    idle(3);
    drive(1, 0, 0, 0, 0, 4, 1, 0); step();
    drive(1, 4, 1, 0, 0, 7, 1, 1); step();
    chk("hold_pre_a", 32'(fwd_a_sel), 32'(2'b01));
    drive(1, 0, 0, 7, 1, 9, 1, 0);
    hold = 1'b1;
    #1;
    chk("hold_stall", 32'(stall), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_a", 32'(fwd_a_sel), 32'(2'b01));
      chk("hold_b", 32'(fwd_b_sel), 0);
      chk("hold_stall_keep", 32'(stall), 1);
    end
    hold = 1'b0;
    step();
    chk("unhold_bubble_a", 32'(fwd_a_sel), 0);
    chk("unhold_bubble_b", 32'(fwd_b_sel), 0);
    step();
    chk("unhold_fwd_b", 32'(fwd_b_sel), 32'(2'b10));

    // Reset asserted mid-stall
    idle(3);
    drive(1, 0, 0, 0, 0, 7, 1, 1); step();
    drive(1, 7, 1, 0, 0, 8, 1, 0);
    #1;
    chk("mid_pre_stall", 32'(stall), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(stall), 0);
    chk("mid_rst_a", 32'(fwd_a_sel), 0);
    chk("mid_rst_b", 32'(fwd_b_sel), 0);
    #1;
    rst_n = 1'b1;

    // Randomized traffic on a small register window to provoke hits
    for (int n = 0; n < 3000; n++) begin
      step();
      drive(($urandom_range(0, 7) != 0) ? 1 : 0,
            int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 2) == 0));
      hold  = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
    end

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Forwarding and load-use hazard controller for the 5-stage pipeline. Tracks destination-register tags of instructions in EX, MEM and WB. Produces registered 2-bit select codes for the two 32-bit 3:1 ALU operand muxes in EX, and a combinational stall request for the fetch/decode stages. Sits between decode and the EX operand muxes; the select codes drive those muxes directly.

## Interface
Parameters:
- REG_W, 5, register-index width
- none other

Ports:
- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- hold  input  1  global pipeline freeze (memory wait); all state held
- flush  input  1  discard instruction currently in ID (taken branch/jump)
- id_valid  input  1  ID holds a real instruction
- id_rs1, id_rs2  input  REG_W  source indices of ID instruction
- id_use_rs1, id_use_rs2  input  1  source actually read
- id_rd  input  REG_W  destination index
- id_regwrite  input  1  ID instruction writes rd
- id_memread  input  1  ID instruction is a load
- fwd_a_sel, fwd_b_sel  output  2  operand A/B mux select, valid during EX cycle
- stall  output  1  hold PC and IF/ID, bubble into EX

## Operation
- Select encoding: 2'b00 register-file value, 2'b01 EX/MEM ALU result, 2'b10 MEM/WB write-back value. 2'b11 never driven.
- Internal tag registers: EX stage (ex_rd, ex_we, ex_ld), MEM stage (mem_rd, mem_we), WB stage (wb_rd, wb_we). WB tags track the write-back instruction only; the register file is write-first, so no WB forwarding is required.
- Load-use detect (combinational): hz = id_valid & ex_ld & ex_we & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- stall = hz & ~flush. Flush masks stall. hold does not affect stall.
- Each rising edge with hold=0:
  - MEM tags move to WB.
  - EX tags move to MEM.
  - EX tags load from ID if id_valid & ~flush & ~hz; otherwise load a bubble (ex_we=0, ex_ld=0, ex_rd=0).
  - fwd_a_sel computed for the instruction entering EX:
    - 01 if id_use_rs1, id_rs1!=0, current ex_we and ex_rd==id_rs1.
    - else 10 if id_use_rs1, id_rs1!=0, current mem_we and mem_rd==id_rs1.
    - else 00.
  - fwd_b_sel computed the same way from rs2.
  - On a bubble, both selects load 00.
- Priority: the newer producer (EX/MEM, 01) wins over the older (MEM/WB, 10). Register 0 is never forwarded.
- With hold=1, all tag and select registers keep their values, regardless of flush or hazard.

## Timing
- Reset (rst_n low, asynchronous): all tags 0, we/ld bits 0, fwd_a_sel=fwd_b_sel=00, stall=0 (no valid EX load exists).
- Select latency: one cycle. Values computed from ID at edge N are stable throughout the EX cycle that follows.
- stall has zero latency: combinational from ID inputs and EX tags, same cycle.
- Load-use sequence:
  - Cycle k: stall=1.
  - Edge: bubble enters EX, load moves to MEM.
  - Cycle k+1: stall=0; the same ID instruction is presented again.
  - Next edge: its select becomes 10.
- Back-to-back producers to the same rd: the most recent one is forwarded.
- Reset asserted mid-stall: stall drops immediately; all selects are 00.

## Test plan
- Reset: rst_n=0 with arbitrary inputs -> selects 00 and stall 0, asynchronously; both hold after release with id_valid=0.
- ALU chain: ID add rd=5, then ID sub rs1=5 rs2=5 -> in sub's EX cycle, fwd_a_sel=01 and fwd_b_sel=01; one unrelated instruction between them -> both 10.
- Load-use: ID lw rd=7, then ID rs2=7 -> stall=1 for exactly one cycle, a bubble reaches EX (selects 00), then fwd_b_sel=10, fwd_a_sel=00.
- x0 and priority: a producer writing rd=0 -> consumer selects stay 00. Producers rd=3 in MEM and rd=3 in EX -> select 01.
- Flush vs hazard: a load-use condition with flush=1 -> stall=0 and a bubble enters EX; with hold=1 over 3 cycles -> selects and tags unchanged, stall still follows hz.
